// File: rtl/mem_pair_sched.sv
// mem_pair_sched: serialises the two issue lines' memory requests onto the
// single data-SRAM port. Line1 always goes before line2, and only one SRAM
// transaction is outstanding at a time. Read data is captured per line.
module mem_pair_sched #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              line1_req_i,
  input  logic              line2_req_i,
  input  logic              line1_wr_i,
  input  logic              line2_wr_i,
  input  logic [1:0]        line1_size_i,
  input  logic [1:0]        line2_size_i,
  input  logic [ADDR_W-1:0] line1_addr_i,
  input  logic [ADDR_W-1:0] line2_addr_i,
  input  logic [DATA_W-1:0] line1_wdata_i,
  input  logic [DATA_W-1:0] line2_wdata_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] line1_rdata_o,
  output logic [DATA_W-1:0] line2_rdata_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  output logic [3:0]        data_wstrb_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ1  = 3'd1;
  localparam logic [2:0] WAIT1 = 3'd2;
  localparam logic [2:0] REQ2  = 3'd3;
  localparam logic [2:0] WAIT2 = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;
  localparam logic [2:0] DRAIN = 3'd6;

  // Note: rst_n is active-high (1 = reset) despite its name.
  logic [2:0]        state_q, state_d;
  logic              l1_req_q, l1_req_d, l2_req_q, l2_req_d;
  logic              l1_wr_q, l1_wr_d, l2_wr_q, l2_wr_d;
  logic [1:0]        l1_size_q, l1_size_d, l2_size_q, l2_size_d;
  logic [ADDR_W-1:0] l1_addr_q, l1_addr_d, l2_addr_q, l2_addr_d;
  logic [DATA_W-1:0] l1_wdata_q, l1_wdata_d, l2_wdata_q, l2_wdata_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;

  assign ready_o       = (state_q == IDLE);
  assign done_o        = (state_q == RESP);
  assign line1_rdata_o = rdata1_q;
  assign line2_rdata_o = rdata2_q;

  // Drive the SRAM port from the latched fields of the line being requested;
  // the fields are registers, so they stay stable until addr_ok.
  always_comb begin
    logic       sel2;
    logic [1:0] lane;
    sel2         = (state_q == REQ2);
    data_req_o   = (state_q == REQ1) || sel2;
    data_wr_o    = sel2 ? l2_wr_q    : l1_wr_q;
    data_size_o  = sel2 ? l2_size_q  : l1_size_q;
    data_addr_o  = sel2 ? l2_addr_q  : l1_addr_q;
    data_wdata_o = sel2 ? l2_wdata_q : l1_wdata_q;
    lane         = data_addr_o[1:0];
    data_wstrb_o = 4'b0000;
    if (data_wr_o) begin
      case (data_size_o)
        2'd0:    data_wstrb_o = 4'b0001 << lane;
        2'd1:    data_wstrb_o = 4'b0011 << {lane[1], 1'b0};
        default: data_wstrb_o = 4'b1111;
      endcase
    end
  end

  // Next-state logic: request sequencing, read-data capture and flush handling.
  always_comb begin
    state_d    = state_q;
    l1_req_d   = l1_req_q;   l2_req_d   = l2_req_q;
    l1_wr_d    = l1_wr_q;    l2_wr_d    = l2_wr_q;
    l1_size_d  = l1_size_q;  l2_size_d  = l2_size_q;
    l1_addr_d  = l1_addr_q;  l2_addr_d  = l2_addr_q;
    l1_wdata_d = l1_wdata_q; l2_wdata_d = l2_wdata_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          l1_req_d   = line1_req_i;   l2_req_d   = line2_req_i;
          l1_wr_d    = line1_wr_i;    l2_wr_d    = line2_wr_i;
          l1_size_d  = line1_size_i;  l2_size_d  = line2_size_i;
          l1_addr_d  = line1_addr_i;  l2_addr_d  = line2_addr_i;
          l1_wdata_d = line1_wdata_i; l2_wdata_d = line2_wdata_i;
          if (line1_req_i)      state_d = REQ1;
          else if (line2_req_i) state_d = REQ2;
          else                  state_d = RESP;
        end
      end
      REQ1, REQ2: begin
        if (data_addr_ok_i)
          state_d = flush_i ? DRAIN : ((state_q == REQ1) ? WAIT1 : WAIT2);
        else if (flush_i)
          state_d = IDLE;
      end
      WAIT1: begin
        if (data_data_ok_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            if (!l1_wr_q) rdata1_d = data_rdata_i;
            state_d = l2_req_q ? REQ2 : RESP;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      WAIT2: begin
        if (data_data_ok_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            if (!l2_wr_q) rdata2_d = data_rdata_i;
            state_d = RESP;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      RESP:    state_d = IDLE;
      DRAIN:   if (data_data_ok_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched line fields and captured read data.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      l1_req_q   <= 1'b0;         l2_req_q   <= 1'b0;
      l1_wr_q    <= 1'b0;         l2_wr_q    <= 1'b0;
      l1_size_q  <= 2'd0;         l2_size_q  <= 2'd0;
      l1_addr_q  <= '0;           l2_addr_q  <= '0;
      l1_wdata_q <= '0;           l2_wdata_q <= '0;
      rdata1_q   <= '0;           rdata2_q   <= '0;
    end else begin
      state_q    <= state_d;
      l1_req_q   <= l1_req_d;     l2_req_q   <= l2_req_d;
      l1_wr_q    <= l1_wr_d;      l2_wr_q    <= l2_wr_d;
      l1_size_q  <= l1_size_d;    l2_size_q  <= l2_size_d;
      l1_addr_q  <= l1_addr_d;    l2_addr_q  <= l2_addr_d;
      l1_wdata_q <= l1_wdata_d;   l2_wdata_q <= l2_wdata_d;
      rdata1_q   <= rdata1_d;     rdata2_q   <= rdata2_d;
    end
  end

endmodule

// File: tb/tb_mem_pair_sched.sv
// Directed testbench for mem_pair_sched: the SRAM side is driven by hand,
// cycle by cycle, and outputs are checked #1 after each rising edge.
module tb_mem_pair_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, flush = 1'b0;
  logic        l1Req = 1'b0, l2Req = 1'b0, l1Wr = 1'b0, l2Wr = 1'b0;
  logic [1:0]  l1Size = 2'd0, l2Size = 2'd0;
  logic [31:0] l1Addr = '0, l2Addr = '0, l1Wdata = '0, l2Wdata = '0;
  logic        addrOk = 1'b0, dataOk = 1'b0;
  logic [31:0] sramRdata = '0;
  logic        ready, done, dReq, dWr;
  logic [1:0]  dSize;
  logic [31:0] rdata1, rdata2, dAddr, dWdata;
  logic [3:0]  dWstrb;
  int          nCompared = 0;
  int          nMismatched = 0;

  mem_pair_sched #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst), .start_i(start),
    .line1_req_i(l1Req), .line2_req_i(l2Req),
    .line1_wr_i(l1Wr), .line2_wr_i(l2Wr),
    .line1_size_i(l1Size), .line2_size_i(l2Size),
    .line1_addr_i(l1Addr), .line2_addr_i(l2Addr),
    .line1_wdata_i(l1Wdata), .line2_wdata_i(l2Wdata),
    .flush_i(flush), .ready_o(ready), .done_o(done),
    .line1_rdata_o(rdata1), .line2_rdata_o(rdata2),
    .data_req_o(dReq), .data_wr_o(dWr), .data_size_o(dSize),
    .data_addr_o(dAddr), .data_wdata_o(dWdata), .data_wstrb_o(dWstrb),
    .data_addr_ok_i(addrOk), .data_data_ok_i(dataOk), .data_rdata_i(sramRdata)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair of line requests with start asserted for this cycle.
  task automatic applyStimulus(input logic r1, input logic w1, input logic [1:0] s1,
                               input logic [31:0] a1, input logic [31:0] wd1,
                               input logic r2, input logic w2, input logic [1:0] s2,
                               input logic [31:0] a2, input logic [31:0] wd2);
    start = 1'b1;
    l1Req = r1; l1Wr = w1; l1Size = s1; l1Addr = a1; l1Wdata = wd1;
    l2Req = r2; l2Wr = w2; l2Size = s2; l2Addr = a2; l2Wdata = wd2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] assertion on %s", tag);
    end
  endtask

  initial begin
    // Reset state
    tick();
    checkOutput("rst_ready", {31'd0, ready}, 32'd1);
    checkOutput("rst_req", {31'd0, dReq}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_rdata1", rdata1, 32'd0);
    rst = 1'b0;
    tick();

    // Two loads, zero-wait SRAM
    applyStimulus(1, 0, 2, 32'h100, 32'h0, 1, 0, 2, 32'h104, 32'h0);    // c0
    checkOutput("ld_c0_ready", {31'd0, ready}, 32'd1);
    tick(); start = 1'b0;                                                // c1
    checkOutput("ld_c1_req", {31'd0, dReq}, 32'd1);
    checkOutput("ld_c1_addr", dAddr, 32'h100);
    checkOutput("ld_c1_wstrb", {28'd0, dWstrb}, 32'd0);
    checkOutput("ld_c1_ready", {31'd0, ready}, 32'd0);
    addrOk = 1'b1;
    tick(); addrOk = 1'b0;                                               // c2
    checkOutput("ld_c2_req", {31'd0, dReq}, 32'd0);
    dataOk = 1'b1; sramRdata = 32'hAAAA5555;
    tick(); dataOk = 1'b0;                                               // c3
    checkOutput("ld_c3_req", {31'd0, dReq}, 32'd1);
    checkOutput("ld_c3_addr", dAddr, 32'h104);
    addrOk = 1'b1;
    tick(); addrOk = 1'b0;                                               // c4
    checkOutput("ld_c4_req", {31'd0, dReq}, 32'd0);
    checkOutput("ld_c4_done", {31'd0, done}, 32'd0);
    dataOk = 1'b1; sramRdata = 32'h12345678;
    tick(); dataOk = 1'b0;                                               // c5
    checkOutput("ld_c5_done", {31'd0, done}, 32'd1);
    checkOutput("ld_c5_ready", {31'd0, ready}, 32'd0);
    checkOutput("ld_rdata1", rdata1, 32'hAAAA5555);
    checkOutput("ld_rdata2", rdata2, 32'h12345678);
    tick();                                                              // c6
    checkOutput("ld_c6_done", {31'd0, done}, 32'd0);
    checkOutput("ld_c6_ready", {31'd0, ready}, 32'd1);

    // Two stores, addr_ok delayed by two cycles on each request
    applyStimulus(1, 1, 0, 32'h103, 32'h11000000, 1, 1, 1, 32'h102, 32'h22330000);
    tick(); start = 1'b0;                                                // c1
    checkOutput("st_c1_req", {31'd0, dReq}, 32'd1);
    checkOutput("st_c1_wr", {31'd0, dWr}, 32'd1);
    checkOutput("st_c1_size", {30'd0, dSize}, 32'd0);
    checkOutput("st_c1_wstrb", {28'd0, dWstrb}, 32'h8);
    tick();                                                              // c2
    checkOutput("st_c2_addr", dAddr, 32'h103);
    checkOutput("st_c2_wdata", dWdata, 32'h11000000);
    tick();                                                              // c3
    checkOutput("st_c3_req", {31'd0, dReq}, 32'd1);
    checkOutput("st_c3_addr", dAddr, 32'h103);
    addrOk = 1'b1;
    tick(); addrOk = 1'b0;                                               // c4
    checkOutput("st_c4_req", {31'd0, dReq}, 32'd0);
    dataOk = 1'b1; sramRdata = 32'hFFFFFFFF;
    tick(); dataOk = 1'b0;                                               // c5
    checkOutput("st_c5_req", {31'd0, dReq}, 32'd1);
    checkOutput("st_c5_addr", dAddr, 32'h102);
    checkOutput("st_c5_wstrb", {28'd0, dWstrb}, 32'hC);
    checkOutput("st_c5_wdata", dWdata, 32'h22330000);
    tick();                                                              // c6
    tick();                                                              // c7
    checkOutput("st_c7_req", {31'd0, dReq}, 32'd1);
    addrOk = 1'b1;
    tick(); addrOk = 1'b0;                                               // c8
    checkOutput("st_c8_req", {31'd0, dReq}, 32'd0);
    checkOutput("st_c8_done", {31'd0, done}, 32'd0);
    dataOk = 1'b1; sramRdata = 32'hEEEEEEEE;
    tick(); dataOk = 1'b0;                                               // c9
    checkOutput("st_c9_done", {31'd0, done}, 32'd1);
    checkOutput("st_rdata1_kept", rdata1, 32'hAAAA5555);
    checkOutput("st_rdata2_kept", rdata2, 32'h12345678);
    tick();

    // No-access pair
    applyStimulus(0, 0, 2, 32'h40, 32'h0, 0, 0, 2, 32'h44, 32'h0);
    tick(); start = 1'b0;                                                // c1
    checkOutput("na_c1_done", {31'd0, done}, 32'd1);
    checkOutput("na_c1_req", {31'd0, dReq}, 32'd0);
    tick();
    checkOutput("na_c2_ready", {31'd0, ready}, 32'd1);

    // Only line2 loads
    applyStimulus(0, 0, 2, 32'h500, 32'h0, 1, 0, 2, 32'h200, 32'h0);
    tick(); start = 1'b0;                                                // c1
    checkOutput("l2_c1_req", {31'd0, dReq}, 32'd1);
    checkOutput("l2_c1_addr", dAddr, 32'h200);
    addrOk = 1'b1;
    tick(); addrOk = 1'b0;                                               // c2
    dataOk = 1'b1; sramRdata = 32'hCAFEF00D;
    tick(); dataOk = 1'b0;                                               // c3
    checkOutput("l2_c3_done", {31'd0, done}, 32'd1);
    checkOutput("l2_rdata2", rdata2, 32'hCAFEF00D);
    checkOutput("l2_rdata1_kept", rdata1, 32'hAAAA5555);
    tick();

    // Flush in WAIT1, data_ok arrives three cycles later
    applyStimulus(1, 0, 2, 32'h300, 32'h0, 1, 0, 2, 32'h304, 32'h0);
    tick(); start = 1'b0; addrOk = 1'b1;                                 // c1 REQ1
    tick(); addrOk = 1'b0; flush = 1'b1;                                 // c2 WAIT1
    tick(); flush = 1'b0;                                                // c3 DRAIN
    for (int i = 0; i < 3; i++) begin
      checkOutput("fw_drain_req", {31'd0, dReq}, 32'd0);
      checkOutput("fw_drain_done", {31'd0, done}, 32'd0);
      checkOutput("fw_drain_ready", {31'd0, ready}, 32'd0);
      if (i == 2) begin dataOk = 1'b1; sramRdata = 32'hDEADBEEF; end
      tick();
    end
    dataOk = 1'b0;
    checkOutput("fw_after_ready", {31'd0, ready}, 32'd1);
    checkOutput("fw_after_done", {31'd0, done}, 32'd0);
    checkOutput("fw_after_req", {31'd0, dReq}, 32'd0);
    checkOutput("fw_rdata1_kept", rdata1, 32'hAAAA5555);

    // Flush in REQ1 without addr_ok: request dropped
    applyStimulus(1, 0, 2, 32'h600, 32'h0, 0, 0, 2, 32'h0, 32'h0);
    tick(); start = 1'b0; flush = 1'b1;                                  // c1 REQ1
    checkOutput("fr_c1_req", {31'd0, dReq}, 32'd1);
    tick(); flush = 1'b0;                                                // c2
    checkOutput("fr_c2_req", {31'd0, dReq}, 32'd0);
    checkOutput("fr_c2_ready", {31'd0, ready}, 32'd1);

    // Flush in REQ1 with addr_ok: drain until data_ok
    applyStimulus(1, 0, 2, 32'h700, 32'h0, 1, 0, 2, 32'h704, 32'h0);
    tick(); start = 1'b0; flush = 1'b1; addrOk = 1'b1;                   // c1 REQ1
    tick(); flush = 1'b0; addrOk = 1'b0;                                 // c2 DRAIN
    checkOutput("fa_c2_req", {31'd0, dReq}, 32'd0);
    checkOutput("fa_c2_ready", {31'd0, ready}, 32'd0);
    tick();                                                              // c3 DRAIN
    checkOutput("fa_c3_ready", {31'd0, ready}, 32'd0);
    dataOk = 1'b1; sramRdata = 32'h0BADF00D;
    tick(); dataOk = 1'b0;                                               // c4
    checkOutput("fa_c4_ready", {31'd0, ready}, 32'd1);
    checkOutput("fa_c4_done", {31'd0, done}, 32'd0);

    // Reset asserted mid-WAIT2
    applyStimulus(1, 0, 2, 32'h800, 32'h0, 1, 0, 2, 32'h804, 32'h0);
    tick(); start = 1'b0; addrOk = 1'b1;                                 // c1 REQ1
    tick(); addrOk = 1'b0; dataOk = 1'b1; sramRdata = 32'h5A5A5A5A;      // c2 WAIT1
    tick(); dataOk = 1'b0; addrOk = 1'b1;                                // c3 REQ2
    tick(); addrOk = 1'b0;                                               // c4 WAIT2
    checkOutput("rw_pre_rdata1", rdata1, 32'h5A5A5A5A);
    rst = 1'b1;
    tick();
    checkOutput("rw_ready", {31'd0, ready}, 32'd1);
    checkOutput("rw_req", {31'd0, dReq}, 32'd0);
    checkOutput("rw_done", {31'd0, done}, 32'd0);
    checkOutput("rw_rdata1", rdata1, 32'd0);
    checkOutput("rw_rdata2", rdata2, 32'd0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
